// File: rtl/hyper_rx_packer.sv
// Receive-path byte packer: turns a 16-bit little-endian halfword stream from the
// HyperBus PHY into 32-bit words for the uDMA RX channel. It drops the leading byte on
// odd start addresses, truncates to the programmed length and tags the final word.
module hyper_rx_packer #(
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic                  periph_clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [TRANS_SIZE-1:0] cfg_len_i,
  input  logic                  cfg_odd_i,
  input  logic [15:0]           in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [31:0]           out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic [2:0]            out_bytes_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e                state_q, state_d;
  logic [TRANS_SIZE-1:0] rem_q, rem_d;
  logic                  first_q, first_d;
  logic                  odd_q, odd_d;
  logic [23:0]           acc_q, acc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           odat_q, odat_d;
  logic                  oval_q, oval_d;
  logic                  olast_q, olast_d;
  logic [2:0]            obytes_q, obytes_d;

  logic                  out_free;
  logic                  last_hs;
  logic                  in_ready;
  logic                  accept;
  logic                  single_hi;
  logic                  single_lo;
  logic [15:0]           nb;
  logic [2:0]            b;
  logic [2:0]            n;
  logic [39:0]           comb;
  logic [TRANS_SIZE-1:0] rem_nxt;

  assign out_free  = !oval_q || out_ready_i;
  assign last_hs   = oval_q && out_ready_i && olast_q;
  assign in_ready  = (state_q == StCollect) && (rem_q != '0) && out_free;
  assign accept    = in_ready && in_valid_i;

  // Byte selection: odd start keeps only the upper byte, a final single byte keeps the lower.
  assign single_hi = first_q && odd_q;
  assign single_lo = !single_hi && (rem_q == TRANS_SIZE'(1));
  assign nb        = single_hi ? {8'h00, in_data_i[15:8]} :
                     single_lo ? {8'h00, in_data_i[7:0]}  : in_data_i;
  assign b         = (single_hi || single_lo) ? 3'd1 : 3'd2;
  assign n         = {1'b0, cnt_q} + b;
  // acc is kept zero above cnt bytes, so OR-ing in the shifted new bytes appends them.
  assign comb      = {16'h0000, acc_q} | ({24'h000000, nb} << {cnt_q, 3'b000});
  assign rem_nxt   = rem_q - TRANS_SIZE'(b);

  // State and datapath registers.
  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      first_q  <= 1'b0;
      odd_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      odat_q   <= '0;
      oval_q   <= 1'b0;
      olast_q  <= 1'b0;
      obytes_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      odd_q    <= odd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      odat_q   <= odat_d;
      oval_q   <= oval_d;
      olast_q  <= olast_d;
      obytes_q <= obytes_d;
    end
  end

  // Next-state: FSM transitions, packing and output-register loads.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    first_d  = first_q;
    odd_d    = odd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    odat_d   = odat_q;
    oval_d   = oval_q && !out_ready_i;
    olast_d  = olast_q;
    obytes_d = obytes_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rem_d   = cfg_len_i;
          first_d = 1'b1;
          odd_d   = cfg_odd_i;
          state_d = (cfg_len_i != '0) ? StCollect : StDone;
        end
      end
      StCollect: begin
        if (accept) begin
          rem_d   = rem_nxt;
          first_d = 1'b0;
          if (n >= 3'd4) begin
            odat_d   = comb[31:0];
            obytes_d = 3'd4;
            oval_d   = 1'b1;
            olast_d  = (rem_nxt == '0) && (n == 3'd4);
            acc_d    = {16'h0000, comb[39:32]};
            cnt_d    = n[1:0];
            if ((rem_nxt == '0) && (n == 3'd5)) begin
              state_d = StFlush;
            end
          end else if (rem_nxt == '0) begin
            odat_d   = comb[31:0];
            obytes_d = n;
            oval_d   = 1'b1;
            olast_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            acc_d = comb[23:0];
            cnt_d = n[1:0];
          end
        end else if (last_hs) begin
          state_d = StDone;
        end
      end
      StFlush: begin
        if (last_hs) begin
          state_d = StDone;
        end else if ((cnt_q != '0) && out_free) begin
          odat_d   = {24'h000000, acc_q[7:0]};
          obytes_d = 3'd1;
          oval_d   = 1'b1;
          olast_d  = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clr_i) begin
      state_d  = StIdle;
      rem_d    = '0;
      first_d  = 1'b0;
      acc_d    = '0;
      cnt_d    = '0;
      oval_d   = 1'b0;
      olast_d  = 1'b0;
      obytes_d = '0;
    end
  end

  // Outputs: sideband is forced to zero whenever no word is presented.
  always_comb begin
    in_ready_o  = in_ready;
    out_data_o  = odat_q;
    out_valid_o = oval_q;
    out_last_o  = oval_q && olast_q;
    out_bytes_o = oval_q ? obytes_q : 3'd0;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_hyper_rx_packer.sv
// Scoreboard bench for hyper_rx_packer: directed transfers push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_hyper_rx_packer;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        start;
  logic [15:0] cfg_len;
  logic        cfg_odd;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0;

  hyper_rx_packer #(.TRANS_SIZE(16)) dut (
    .periph_clk_i(clk),
    .rstn_i      (rstn),
    .clr_i       (clr),
    .start_i     (start),
    .cfg_len_i   (cfg_len),
    .cfg_odd_i   (cfg_odd),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_last_o  (out_last),
    .out_bytes_o (out_bytes),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    exp_t e;
    e.d = d;
    e.b = b;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word got=%h bytes=%0d last=%0b", out_data, out_bytes,
                   out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_bytes !== e.b || out_last !== e.l) begin
            n_bad++;
            $display("FAIL word got=%h/%0d/%0b exp=%h/%0d/%0b", out_data, out_bytes, out_last,
                     e.d, e.b, e.l);
          end
          if (out_last) last_hs_cyc = cyc;
        end
      end
      if (!out_valid) check("bytes_idle", 32'(out_bytes), 32'd0);
    end
  end

  task automatic start_xfer(input int len, input logic odd);
    @(posedge clk); #1;
    cfg_len = 16'(len);
    cfg_odd = odd;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_timeout("send");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_timeout("done");
    else begin
      check("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_bytes"}, 32'(out_bytes), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rstn = 1'b0; clr = 1'b0; start = 1'b0; cfg_len = '0; cfg_odd = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Even start, len 8; a stray start while busy must be ignored.
    start_xfer(8, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    expect_word(32'h44332211, 3'd4, 1'b0);
    expect_word(32'h88776655, 3'd4, 1'b1);
    send(16'h2211);
    start_xfer(2, 1'b1);
    send(16'h4433);
    send(16'h6655);
    send(16'h8877);
    wait_done();
    drain();

    // Odd start, len 3.
    start_xfer(3, 1'b1);
    expect_word(32'h00443322, 3'd3, 1'b1);
    send(16'h2211);
    send(16'h4433);
    wait_done();
    drain();

    // Odd start, len 4: 0x66 dropped, a further halfword is never accepted.
    start_xfer(4, 1'b1);
    expect_word(32'h55443322, 3'd4, 1'b1);
    send(16'h2211);
    send(16'h4433);
    send(16'h6655);
    in_data  = 16'h8877;
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("excess_in_ready", 32'(in_ready), 32'd0);
      if (done) seen = 1;
    end
    in_valid = 1'b0;
    check("len4_done_seen", 32'(seen), 32'd1);
    drain();

    // Odd start, len 5: full word then a one-byte flush word.
    start_xfer(5, 1'b1);
    expect_word(32'h55443322, 3'd4, 1'b0);
    expect_word(32'h00000066, 3'd1, 1'b1);
    send(16'h2211);
    send(16'h4433);
    send(16'h6655);
    wait_done();
    drain();

    // Even start, len 6 with backpressure on the first word.
    out_ready = 1'b0;
    start_xfer(6, 1'b0);
    expect_word(32'h44332211, 3'd4, 1'b0);
    expect_word(32'h00006655, 3'd2, 1'b1);
    send(16'h2211);
    send(16'h4433);
    in_data  = 16'h6655;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h44332211);
      check("bp_bytes", 32'(out_bytes), 32'd4);
      check("bp_last", 32'(out_last), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h6655);
    wait_done();
    drain();

    // Zero length: done one cycle after start, no word.
    start_xfer(0, 1'b0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("len0_done_end", 32'(done), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_valid2", 32'(out_valid), 32'd0);

    // Abort with a word held and one byte left in the accumulator.
    out_ready = 1'b0;
    start_xfer(8, 1'b1);
    send(16'h2211);
    send(16'h4433);
    send(16'h6655);
    @(negedge clk);
    check("pre_clr_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("clr_no_done", 32'(seen), 32'd0);
    start_xfer(2, 1'b0);
    expect_word(32'h0000bbaa, 3'd2, 1'b1);
    send(16'hbbaa);
    wait_done();
    drain();

    // Asynchronous reset mid-transfer.
    out_ready = 1'b0;
    start_xfer(8, 1'b0);
    send(16'h2211);
    send(16'h4433);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;

    start_xfer(3, 1'b1);
    expect_word(32'h00443322, 3'd3, 1'b1);
    send(16'h2211);
    send(16'h4433);
    wait_done();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
